// File: rtl/stb_pkg.sv
// Shared types and helpers for the STB write-port arbiter.
// Pulled in by the top module and by the bench.
package stb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    DATA      = 3'b010,
    WAIT_RESP = 3'b100
  } stb_state_e;

  localparam logic [1:0] RESP_OK      = 2'b01;
  localparam logic [1:0] RESP_TMO_ERR = 2'b10;

  // Low bit of requester idx's field inside a packed per-requester bus.
  function automatic int fld_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/stb_rr_arbiter.sv
// Combinational round-robin pick.
// Returns the first requester at or after the pointer, as a one-hot vector and as an index.
module stb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;

  // Rotate so bit 0 is the pointer position; the lowest set bit is the winner.
  assign w_req2 = {i_req, i_req} >> i_ptr;
  assign w_rot  = w_req2[NUM_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx   = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                  : w_sum[IDX_W-1:0];
  assign o_grant = (|i_req) ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/stb_wr_arbiter.sv
// Shares one write-only burst slave port between NUM_REQ store requesters.
// Grants are round-robin and held for a whole burst plus its response.
module stb_wr_arbiter
  import stb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int BYTE_STRB  = DATA_WIDTH / 8,
  parameter int RESP_TMO   = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*BYTE_STRB-1:0]    req_strb,
  input  logic [NUM_REQ*3-1:0]            req_size,
  input  logic [NUM_REQ*2-1:0]            req_burst,
  input  logic [NUM_REQ*4-1:0]            req_len,
  output logic [NUM_REQ-1:0]              req_accept,
  output logic [NUM_REQ-1:0]              req_resp_valid,
  output logic [1:0]                      req_resp,
  output logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [BYTE_STRB-1:0]            m_wstrb,
  output logic [2:0]                      m_size,
  output logic [1:0]                      m_burst,
  output logic [3:0]                      m_len,
  output logic                            m_write,
  output logic                            m_last,
  output logic                            m_read,
  output logic                            m_ready,
  input  logic                            s_accept,
  input  logic                            s_valid,
  input  logic [1:0]                      s_resp
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RESP_TMO + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RESP_TMO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  stb_state_e         r_state, w_state_nx;
  logic [IDX_W-1:0]   r_grant, w_grant_nx;
  logic [NUM_REQ-1:0] r_grant_oh, w_grant_oh_nx;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nx, w_ptr_inc;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [NUM_REQ-1:0] w_arb_oh;
  logic [IDX_W-1:0]   w_arb_idx;

  logic [ADDR_WIDTH-1:0] w_addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data_a  [NUM_REQ];
  logic [BYTE_STRB-1:0]  w_strb_a  [NUM_REQ];
  logic [2:0]            w_size_a  [NUM_REQ];
  logic [1:0]            w_burst_a [NUM_REQ];
  logic [3:0]            w_len_a   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_a[gi]  = req_addr[fld_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];
    assign w_data_a[gi]  = req_data[fld_lo(gi, DATA_WIDTH) +: DATA_WIDTH];
    assign w_strb_a[gi]  = req_strb[fld_lo(gi, BYTE_STRB) +: BYTE_STRB];
    assign w_size_a[gi]  = req_size[fld_lo(gi, 3) +: 3];
    assign w_burst_a[gi] = req_burst[fld_lo(gi, 2) +: 2];
    assign w_len_a[gi]   = req_len[fld_lo(gi, 4) +: 4];
  end

  stb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req   (req_write),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_oh),
    .o_idx   (w_arb_idx)
  );

  assign w_ptr_inc = (r_grant == IDX_LAST) ? '0 : r_grant + 1'b1;
  assign m_read    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_grant_oh <= w_grant_oh_nx;
      r_ptr      <= w_ptr_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_grant_nx     = r_grant;
    w_grant_oh_nx  = r_grant_oh;
    w_ptr_nx       = r_ptr;
    w_cnt_nx       = r_cnt;
    req_accept     = '0;
    req_resp_valid = '0;
    req_resp       = '0;
    m_addr         = '0;
    m_data         = '0;
    m_wstrb        = '0;
    m_size         = '0;
    m_burst        = '0;
    m_len          = '0;
    m_write        = 1'b0;
    m_last         = 1'b0;
    m_ready        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (|req_write) begin
          w_grant_nx    = w_arb_idx;
          w_grant_oh_nx = w_arb_oh;
          w_state_nx    = DATA;
        end
      end

      // Owner keeps the port across bubbles; other requesters are not looked at here.
      DATA: begin
        m_addr     = w_addr_a[r_grant];
        m_data     = w_data_a[r_grant];
        m_wstrb    = w_strb_a[r_grant];
        m_size     = w_size_a[r_grant];
        m_burst    = w_burst_a[r_grant];
        m_len      = w_len_a[r_grant];
        m_last     = req_last[r_grant];
        m_write    = req_write[r_grant] & s_accept;
        req_accept = r_grant_oh & {NUM_REQ{m_write}};
        if (m_write && req_last[r_grant]) begin
          w_state_nx = WAIT_RESP;
          w_cnt_nx   = '0;
        end
      end

      // A real response wins over a timeout landing in the same cycle.
      WAIT_RESP: begin
        m_ready  = 1'b1;
        w_cnt_nx = r_cnt + 1'b1;
        if (s_valid || (r_cnt == TMO_LAST)) begin
          req_resp_valid = r_grant_oh;
          req_resp       = s_valid ? s_resp : RESP_TMO_ERR;
          w_ptr_nx       = w_ptr_inc;
          w_state_nx     = IDLE;
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stb_wr_arbiter.sv
// Directed bench for stb_wr_arbiter with per-requester beat scoreboards,
// an expected-owner queue and a bench-side slave response model.
module tb_stb_wr_arbiter;
  import stb_pkg::*;

  localparam int NR  = 2;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_write, req_last;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR*SW-1:0]  req_strb;
  logic [NR*3-1:0]   req_size;
  logic [NR*2-1:0]   req_burst;
  logic [NR*4-1:0]   req_len;
  logic [NR-1:0]     req_accept, req_resp_valid;
  logic [1:0]        req_resp;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_data;
  logic [SW-1:0]     m_wstrb;
  logic [2:0]        m_size;
  logic [1:0]        m_burst;
  logic [3:0]        m_len;
  logic              m_write, m_last, m_read, m_ready;
  logic              s_accept, s_valid;
  logic [1:0]        s_resp;

  stb_wr_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_STRB(SW), .RESP_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_write(req_write), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
    .req_strb(req_strb), .req_size(req_size), .req_burst(req_burst), .req_len(req_len),
    .req_accept(req_accept), .req_resp_valid(req_resp_valid), .req_resp(req_resp),
    .m_addr(m_addr), .m_data(m_data), .m_wstrb(m_wstrb), .m_size(m_size),
    .m_burst(m_burst), .m_len(m_len), .m_write(m_write), .m_last(m_last),
    .m_read(m_read), .m_ready(m_ready),
    .s_accept(s_accept), .s_valid(s_valid), .s_resp(s_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic last; logic [3:0] len; } beat_t;
  typedef struct { int owner; int lat; logic [1:0] code; } burst_t;

  beat_t  drv_q [NR][$];
  beat_t  exp_q [NR][$];
  burst_t own_q [$];
  burst_t cur;
  int     cur_owner = -1;
  bit     in_wait = 1'b0;
  int     wait_k = 0;
  int     cyc = 0;
  int     first_mw_cyc = -1;
  int     req_cyc = 0;
  bit     sacc = 1'b1;
  bit     stray = 1'b0;
  int     n_total = 0;
  int     n_pass = 0;

  function automatic logic [DW-1:0] beat_data(input int r, input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, AW'(r)};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  task automatic add_burst(input int r, input logic [AW-1:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.addr = base + AW'(k);
      b.last = (k == n - 1);
      b.len  = 4'(n - 1);
      drv_q[r].push_back(b);
      exp_q[r].push_back(b);
    end
  endtask

  // lat = WAIT_RESP cycle (1-based) in which the slave answers; 0 = never.
  task automatic exp_burst(input int owner, input int lat, input logic [1:0] code);
    burst_t t;
    t.owner = owner;
    t.lat   = lat;
    t.code  = code;
    own_q.push_back(t);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (drv_q[i].size() > 0) begin
        req_write[i]          = 1'b1;
        req_last[i]           = drv_q[i][0].last;
        req_addr[i*AW +: AW]  = drv_q[i][0].addr;
        req_data[i*DW +: DW]  = beat_data(i, drv_q[i][0].addr);
        req_strb[i*SW +: SW]  = '1;
        req_size[i*3 +: 3]    = 3'b100;
        req_burst[i*2 +: 2]   = 2'b01;
        req_len[i*4 +: 4]     = drv_q[i][0].len;
      end else begin
        req_write[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_data[i*DW +: DW]  = '0;
        req_strb[i*SW +: SW]  = '0;
        req_size[i*3 +: 3]    = '0;
        req_burst[i*2 +: 2]   = '0;
        req_len[i*4 +: 4]     = '0;
      end
    end
    s_accept = sacc;
    s_valid  = 1'b0;
    s_resp   = 2'b00;
    if (in_wait) begin
      wait_k++;
      if (wait_k == cur.lat) begin
        s_valid = 1'b1;
        s_resp  = cur.code;
      end
    end
    if (stray) begin
      s_valid = 1'b1;
      s_resp  = RESP_OK;
      stray   = 1'b0;
    end
  endtask

  task automatic monitor();
    logic [NR-1:0] exp_rv;
    logic [1:0]    exp_r;
    bit            set_wait;
    beat_t         e;
    exp_rv   = '0;
    exp_r    = '0;
    set_wait = 1'b0;
    chk("m_read", m_read, 1'b0);
    chk("m_ready", m_ready, in_wait);
    if (!s_accept) chk("stall_m_write", m_write, 1'b0);
    if (!m_write) begin
      chk("accept_no_beat", req_accept, '0);
    end else begin
      if (cur_owner < 0) begin
        if (own_q.size() == 0) chk("unexpected_burst", m_write, 1'b0);
        else begin
          cur       = own_q.pop_front();
          cur_owner = cur.owner;
          if (first_mw_cyc < 0) first_mw_cyc = cyc;
        end
      end
      if (cur_owner >= 0) begin
        chk("accept_owner", req_accept, NR'(1) << cur_owner);
        if (exp_q[cur_owner].size() == 0) chk("extra_beat", m_write, 1'b0);
        else begin
          e = exp_q[cur_owner].pop_front();
          chk("beat_addr", m_addr, e.addr);
          chk("beat_data", m_data, beat_data(cur_owner, e.addr));
          chk("beat_last", m_last, e.last);
          chk("beat_len", m_len, e.len);
          chk("beat_strb", m_wstrb, {SW{1'b1}});
          set_wait = e.last;
        end
      end
    end
    for (int i = 0; i < NR; i++)
      if (req_accept[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
    if (in_wait && (s_valid || wait_k == TMO)) begin
      exp_rv    = NR'(1) << cur_owner;
      exp_r     = s_valid ? s_resp : RESP_TMO_ERR;
      in_wait   = 1'b0;
      cur_owner = -1;
    end
    chk("resp_valid", req_resp_valid, exp_rv);
    chk("resp_code", req_resp, exp_r);
    if (set_wait) begin
      in_wait = 1'b1;
      wait_k  = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    monitor();
  endtask

  function automatic bit bench_idle();
    bit idle;
    idle = (own_q.size() == 0) && (cur_owner < 0) && !in_wait;
    for (int i = 0; i < NR; i++)
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input int max_cyc);
    for (int n = 0; n < max_cyc; n++) begin
      if (bench_idle()) break;
      cycle();
    end
    chk("drain_done", bench_idle(), 1'b1);
  endtask

  task automatic run_until_left(input int r, input int left, input int max_cyc);
    for (int n = 0; n < max_cyc; n++) begin
      if (drv_q[r].size() == left) break;
      cycle();
    end
    chk("reach_beat", drv_q[r].size(), left);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {req_accept, req_resp_valid, req_resp, m_addr, m_data, m_wstrb, m_size,
              m_burst, m_len, m_write, m_last, m_read, m_ready}, '0);
  endtask

  initial begin
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_outputs");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single 4-beat burst from req0, slave answers OK in the 2nd wait cycle.
    req_cyc      = cyc + 1;
    first_mw_cyc = -1;
    add_burst(0, 32'h10, 4);
    exp_burst(0, 2, RESP_OK);
    drain(100);
    chk("first_beat_latency", first_mw_cyc, req_cyc + 1);

    // Single-beat burst from req1.
    add_burst(1, 32'h200, 1);
    exp_burst(1, 1, 2'b00);
    drain(100);

    // Both requesting continuously: 0,1,0,1; 2nd response lands on the timeout cycle.
    add_burst(0, 32'h300, 2);
    add_burst(1, 32'h400, 3);
    add_burst(0, 32'h310, 1);
    add_burst(1, 32'h410, 2);
    exp_burst(0, 3, RESP_OK);
    exp_burst(1, TMO, 2'b11);
    exp_burst(0, 1, RESP_OK);
    exp_burst(1, 2, 2'b00);
    drain(300);

    // Slave back-pressure for 5 cycles mid-burst.
    add_burst(0, 32'h500, 4);
    exp_burst(0, 1, RESP_OK);
    run_until_left(0, 2, 50);
    sacc = 1'b0;
    repeat (5) cycle();
    sacc = 1'b1;
    drain(100);

    // Silent slave on req1 -> timeout, then req0 served; then a stray s_valid in IDLE.
    add_burst(1, 32'h600, 2);
    add_burst(0, 32'h700, 1);
    exp_burst(1, 0, 2'b00);
    exp_burst(0, 3, RESP_OK);
    drain(200);
    stray = 1'b1;
    cycle();
    cycle();

    // Reset during beat 2 of a 4-beat burst; pointer (was 1) must return to 0.
    add_burst(1, 32'h800, 4);
    exp_burst(1, 1, RESP_OK);
    run_until_left(1, 2, 50);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_mid_burst");
    for (int i = 0; i < NR; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    own_q.delete();
    cur_owner = -1;
    in_wait   = 1'b0;
    drive();
    @(negedge clk);
    chk_zero("reset_held");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    add_burst(1, 32'h900, 1);
    add_burst(0, 32'hA00, 2);
    exp_burst(0, 1, RESP_OK);
    exp_burst(1, 2, RESP_OK);
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
